// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls,
// taken-branch flushes and the multi-cycle MDU wait.
// Optional feature macro: HAZARD_PERF_CNT_EN (stall/flush perf counters).
module pipeline_hazard_ctrl #(
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_memread,
  input  logic              ex_is_mdu,
  input  logic              ex_branch_taken,
  input  logic              mdu_done,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_bubble,
  output logic              mdu_start,
  output logic              mdu_err,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events
);

  typedef enum logic {RUN, MDU_BUSY} state_e;

  localparam logic [7:0] TIMER_LAST = 8'(MDU_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic       mdu_err_q, mdu_err_d;
  logic       load_use;

  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

  // Next-state and output decode from registered state plus current inputs
  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    id_ex_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    mdu_start     = 1'b0;
    state_d       = state_q;
    timer_d       = timer_q;
    mdu_err_d     = mdu_err_q;

    if (!rst_n) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_bubble  = 1'b1;
      ex_mem_bubble = 1'b1;
      state_d       = RUN;
      timer_d       = '0;
      mdu_err_d     = 1'b0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (ex_is_mdu) begin
            mdu_start     = 1'b1;
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_bubble = 1'b1;
            state_d       = MDU_BUSY;
            timer_d       = '0;
          end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so a load-use match is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
        MDU_BUSY: begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
          timer_d       = timer_q + 8'd1;
          // A timeout retires the operation exactly like a done pulse
          if (mdu_done || (timer_q == TIMER_LAST)) begin
            id_ex_write   = 1'b1;
            ex_mem_bubble = 1'b0;
            state_d       = RUN;
            if (!mdu_done) mdu_err_d = 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  // State, MDU timer and sticky error register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= RUN;
      timer_q   <= '0;
      mdu_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      mdu_err_q <= mdu_err_d;
    end
  end

  assign mdu_err = mdu_err_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  // Saturating perf counters; reset cycles are never counted
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (rst_n && !pc_write && (stall_q != '1)) stall_d = stall_q + 1'b1;
    if (rst_n && if_id_flush && (flush_q != '1)) flush_d = flush_q + 1'b1;
  end

  // Counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed, table-driven bench for pipeline_hazard_ctrl (MDU_TIMEOUT=8).
module tb_pipeline_hazard_ctrl;

  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [4:0]       id_rs1, id_rs2, ex_rd;
  logic             id_uses_rs2, ex_memread, ex_is_mdu, ex_branch_taken, mdu_done;
  logic             pc_write, if_id_write, id_ex_write, if_id_flush;
  logic             id_ex_bubble, ex_mem_bubble, mdu_start, mdu_err;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl #(.REG_AW(5), .MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_is_mdu(ex_is_mdu),
    .ex_branch_taken(ex_branch_taken), .mdu_done(mdu_done),
    .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .ex_mem_bubble(ex_mem_bubble), .mdu_start(mdu_start), .mdu_err(mdu_err),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  // exp = {pc_write, if_id_write, id_ex_write, if_id_flush,
  //        id_ex_bubble, ex_mem_bubble, mdu_start, mdu_err}
  typedef struct {
    string      name;
    logic       rst_n;
    logic [4:0] rs1, rs2;
    logic       uses;
    logic [4:0] rd;
    logic       mr, mdu, br, done;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  function automatic vec_t mk(string name, logic r, logic [4:0] rs1, logic [4:0] rs2,
                              logic uses, logic [4:0] rd, logic mr, logic mdu,
                              logic br, logic done, logic [7:0] exp);
    vec_t v;
    v.name = name; v.rst_n = r; v.rs1 = rs1; v.rs2 = rs2; v.uses = uses;
    v.rd = rd; v.mr = mr; v.mdu = mdu; v.br = br; v.done = done; v.exp = exp;
    return v;
  endfunction

  task automatic check_cnt(string name);
    total++;
    if (stall_cycles !== exp_stall || flush_events !== exp_flush) begin
      bad++;
      $display("FAIL %s counters: got stall=%0d flush=%0d want stall=%0d flush=%0d",
               name, stall_cycles, flush_events, exp_stall, exp_flush);
    end
  endtask

  initial begin
    logic [7:0] got;
    // Reset, forced outputs even with an MDU op presented
    vecs.push_back(mk("rst0",      0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0001_1100));
    vecs.push_back(mk("rst_mdu",   0, 0, 0, 0, 0, 0, 1, 0, 0, 8'b0001_1100));
    vecs.push_back(mk("idle",      1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1110_0000));
    // Load-use on rs1, then released
    vecs.push_back(mk("lu_rs1",    1, 5, 3, 1, 5, 1, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk("lu_after",  1, 5, 3, 1, 6, 0, 0, 0, 0, 8'b1110_0000));
    vecs.push_back(mk("lu_rs2",    1, 1, 7, 1, 7, 1, 0, 0, 0, 8'b0010_1000));
    vecs.push_back(mk("rs2_nouse", 1, 1, 7, 0, 7, 1, 0, 0, 0, 8'b1110_0000));
    vecs.push_back(mk("rd_zero",   1, 0, 0, 1, 0, 1, 0, 0, 0, 8'b1110_0000));
    // Branch wins over load-use
    vecs.push_back(mk("br_lu",     1, 5, 0, 0, 5, 1, 0, 1, 0, 8'b1111_1000));
    vecs.push_back(mk("br",        1, 2, 0, 0, 9, 0, 0, 1, 0, 8'b1111_1000));
    vecs.push_back(mk("done_run",  1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1110_0000));
    // MDU: done arrives on the 4th busy cycle -> 5 stall cycles
    vecs.push_back(mk("mdu_start", 1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b0000_0110));
    vecs.push_back(mk("busy1_hz",  1, 5, 0, 0, 5, 1, 0, 1, 0, 8'b0000_0100));
    vecs.push_back(mk("busy2",     1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0100));
    vecs.push_back(mk("busy3",     1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b0000_0100));
    vecs.push_back(mk("busy4done", 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b0010_0000));
    vecs.push_back(mk("mdu_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1110_0000));
    // MDU priority over branch/load, then timeout after 8 busy cycles
    vecs.push_back(mk("mdu_prio",  1, 5, 0, 0, 5, 1, 1, 1, 0, 8'b0000_0110));
    for (int i = 1; i <= 7; i++)
      vecs.push_back(mk($sformatf("to_busy%0d", i), 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0100));
    vecs.push_back(mk("to_busy8",  1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0010_0000));
    vecs.push_back(mk("err_run",   1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1110_0001));
    vecs.push_back(mk("err_done",  1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1110_0001));
    vecs.push_back(mk("err_lu",    1, 4, 0, 0, 4, 1, 0, 0, 0, 8'b0010_1001));
    // Reset mid-MDU clears error, abandons op; later done has no effect
    vecs.push_back(mk("mdu2",      1, 0, 0, 0, 0, 0, 1, 0, 0, 8'b0000_0111));
    vecs.push_back(mk("mdu2_b1",   1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0101));
    vecs.push_back(mk("mdu2_rst",  0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0001_1101));
    vecs.push_back(mk("post_done", 1, 0, 0, 0, 0, 0, 0, 0, 1, 8'b1110_0000));
    vecs.push_back(mk("post_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b1110_0000));
    vecs.push_back(mk("post_br",   1, 0, 0, 0, 0, 0, 0, 1, 0, 8'b1111_1000));

    rst_n = 0; id_rs1 = 0; id_rs2 = 0; id_uses_rs2 = 0; ex_rd = 0;
    ex_memread = 0; ex_is_mdu = 0; ex_branch_taken = 0; mdu_done = 0;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; id_rs1 = vecs[i].rs1; id_rs2 = vecs[i].rs2;
      id_uses_rs2 = vecs[i].uses; ex_rd = vecs[i].rd; ex_memread = vecs[i].mr;
      ex_is_mdu = vecs[i].mdu; ex_branch_taken = vecs[i].br; mdu_done = vecs[i].done;
      #1;
      got = {pc_write, if_id_write, id_ex_write, if_id_flush,
             id_ex_bubble, ex_mem_bubble, mdu_start, mdu_err};
      total++;
      if (got !== vecs[i].exp) begin
        bad++;
        $display("FAIL %s: got %b want %b (pc,ifid,idex,flush,idb,exb,start,err)",
                 vecs[i].name, got, vecs[i].exp);
      end
      // Counters hold the value accumulated before this cycle (zero in the default build)
      if (i > 1) check_cnt(vecs[i].name);
`ifdef HAZARD_PERF_CNT_EN
      if (!vecs[i].rst_n) begin
        exp_stall = '0;
        exp_flush = '0;
      end else begin
        if (!vecs[i].exp[7]) exp_stall = exp_stall + 1'b1;
        if (vecs[i].exp[4])  exp_flush = exp_flush + 1'b1;
      end
`endif
      @(posedge clk);
    end

    @(negedge clk);
    check_cnt("final");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
